// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch front end: PC, ROM addressing, {pc, insn} FIFO to decode
//
// Owns the PC, drives the combinational instruction ROM, queues fetched
// {pc, insn} pairs and hands them to decode over a valid/ready handshake.
// A redirect from execute flushes the queue and reloads the PC.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   imem_addr      ROM byte address (the PC register)
//   imem_insn      ROM word for imem_addr, same cycle
//   redirect_valid redirect request from execute
//   redirect_pc    redirect target (low two bits ignored)
//   out_valid      FIFO head holds an instruction
//   out_ready      decode accepts the head this cycle
//   out_insn       instruction at the head (0 when not valid)
//   out_pc         PC of out_insn (0 when not valid)
module fetch_stage #(
  parameter int                      address_size = 32,
  parameter int                      word_size    = 32,
  parameter logic [address_size-1:0] reset_pc     = '0,
  parameter int                      depth        = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [address_size-1:0] imem_addr,
  input  logic [word_size-1:0]    imem_insn,
  input  logic                    redirect_valid,
  input  logic [address_size-1:0] redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [word_size-1:0]    out_insn,
  output logic [address_size-1:0] out_pc
);

  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = $clog2(depth + 1);
  localparam logic [cnt_w-1:0] depth_c = cnt_w'(depth);
  localparam logic [address_size-1:0] align_mask = ~address_size'(3);

  logic [address_size-1:0] pc_q, pc_d;
  logic [cnt_w-1:0]        count_q, count_d;
  logic [ptr_w-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ptr_w-1:0]        wr_ptr_q, wr_ptr_d;

  logic [address_size-1:0] mem_pc_q   [depth];
  logic [word_size-1:0]    mem_insn_q [depth];

  logic pop;
  logic fetch;

  assign imem_addr = pc_q;
  assign out_valid = (count_q != '0);
  assign out_insn  = out_valid ? mem_insn_q[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? mem_pc_q[rd_ptr_q]   : '0;

  always_comb begin
    pop   = out_valid & out_ready;
    // A pop frees a slot at the same edge, so a full FIFO can still fetch.
    fetch = !redirect_valid && ((count_q < depth_c) || pop);

    pc_d     = pc_q;
    count_d  = count_q + {{(cnt_w-1){1'b0}}, fetch} - {{(cnt_w-1){1'b0}}, pop};
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (pop)   rd_ptr_d = rd_ptr_q + ptr_w'(1);
    if (fetch) begin
      wr_ptr_d = wr_ptr_q + ptr_w'(1);
      pc_d     = pc_q + address_size'(4);
    end

    // Flush dominates: anything popped this cycle is gone, the rest is dropped.
    if (redirect_valid) begin
      pc_d     = redirect_pc & align_mask;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= reset_pc;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible when count covers them.
  always_ff @(posedge clk) begin
    if (rst_n && fetch) begin
      mem_pc_q[wr_ptr_q]   <= pc_q;
      mem_insn_q[wr_ptr_q] <= imem_insn;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_insn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic [31:0] out_pc;

  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .address_size(32),
    .word_size(32),
    .reset_pc(32'h0000_0000),
    .depth(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_addr(imem_addr),
    .imem_insn(imem_insn),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_insn(out_insn),
    .out_pc(out_pc)
  );

  // ROM contents: three program words, everything else reads as ~addr.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0: return 32'h0050_0093;
      32'h4: return 32'h0030_0113;
      32'h8: return 32'h0020_81b3;
      default: return ~a;
    endcase
  endfunction

  assign imem_insn = rom(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    step();
    step();

    // Reset state
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_pc",    out_pc,    32'h0);
    check("rst_insn",  out_insn,  32'h0);
    check("rst_addr",  imem_addr, 32'h0);

    // Startup with out_ready held high
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    check("start_valid0", {31'b0, out_valid}, 32'h1);
    check("start_pc0",    out_pc,   32'h0);
    check("start_insn0",  out_insn, 32'h0050_0093);
    step();
    check("start_pc1",    out_pc,   32'h4);
    check("start_insn1",  out_insn, 32'h0030_0113);
    step();
    check("start_pc2",    out_pc,   32'h8);
    check("start_insn2",  out_insn, 32'h0020_81b3);
    check("start_valid2", {31'b0, out_valid}, 32'h1);

    // Backpressure: four stalled cycles after release
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    out_ready = 1'b0;
    step();
    step();
    step();
    step();
    check("bp_addr",  imem_addr, 32'h8);
    check("bp_head",  out_pc,    32'h0);
    check("bp_valid", {31'b0, out_valid}, 32'h1);
    out_ready = 1'b1;
    check("bp_drain0", out_pc, 32'h0);
    step();
    check("bp_drain1", out_pc, 32'h4);
    step();
    check("bp_drain2", out_pc, 32'h8);
    check("bp_drain2_insn", out_insn, 32'h0020_81b3);

    // Redirect while full, with a simultaneous pop
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    out_ready = 1'b0;
    step();
    step();
    check("rd_full_addr", imem_addr, 32'h8);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    check("rd_valid_n1", {31'b0, out_valid}, 32'h0);
    check("rd_addr_n1",  imem_addr, 32'h40);
    step();
    check("rd_valid_n2", {31'b0, out_valid}, 32'h1);
    check("rd_pc_n2",    out_pc,   32'h40);
    check("rd_insn_n2",  out_insn, 32'hFFFF_FFBF);
    step();
    check("rd_pc_n3",    out_pc,   32'h44);

    // Misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    step();
    redirect_valid = 1'b0;
    check("mis_addr",  imem_addr, 32'h100);
    check("mis_valid", {31'b0, out_valid}, 32'h0);
    step();
    check("mis_pc",    out_pc, 32'h100);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    check("wrap_pc0",   out_pc,   32'hFFFF_FFFC);
    check("wrap_insn0", out_insn, 32'h0000_0003);
    step();
    check("wrap_pc1",   out_pc,   32'h0);
    check("wrap_insn1", out_insn, 32'h0050_0093);
    step();
    check("wrap_pc2",   out_pc,   32'h4);

    // Mid-run reset with two entries held
    out_ready = 1'b0;
    step();
    check("mr_pre_valid", {31'b0, out_valid}, 32'h1);
    check("mr_pre_addr",  imem_addr, 32'hC);
    rst_n = 1'b0;
    step();
    check("mr_valid", {31'b0, out_valid}, 32'h0);
    check("mr_pc",    out_pc,    32'h0);
    check("mr_insn",  out_insn,  32'h0);
    check("mr_addr",  imem_addr, 32'h0);

    // Redirect during reset: reset wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step();
    redirect_valid = 1'b0;
    check("rr_addr", imem_addr, 32'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    check("mr_restart_pc0", out_pc, 32'h0);
    check("mr_restart_v0",  {31'b0, out_valid}, 32'h1);
    step();
    check("mr_restart_pc1", out_pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch front end that sits directly upstream of the cpu decode logic.
- Owns the PC and drives the instruction ROM address. The ROM returns its word combinationally in the same cycle.
- Captures {pc, insn} pairs into a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts a branch/jump redirect that flushes everything in flight.

Parameters:
- address_size, 32, width of PC and imem_addr
- word_size, 32, width of instruction word
- reset_pc, 32'h0000_0000, PC value loaded on reset
- depth, 2, FIFO entries (power of two, >= 2)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset; synchronous, active-low
- imem_addr  output  address_size  byte address to instruction ROM; equals PC register
- imem_insn  input  word_size  ROM data for imem_addr, valid in the same cycle
- redirect_valid  input  1  redirect request from execute
- redirect_pc  input  address_size  redirect target
- out_valid  output  1  FIFO head holds a valid instruction
- out_ready  input  1  decode accepts the head this cycle
- out_insn  output  word_size  instruction at FIFO head
- out_pc  output  address_size  PC of out_insn

Behaviour:
- Reset (rst_n=0 at a clk edge, at any time including mid-operation):
  - pc <= reset_pc and FIFO count <= 0.
  - Consequently out_valid=0, out_insn=0, out_pc=0 and imem_addr=reset_pc.
- Outputs:
  - imem_addr is combinational from the pc register.
  - out_* are driven from FIFO storage and counters only.
  - out_valid must not depend combinationally on out_ready.
  - When out_valid=0, out_insn=0 and out_pc=0.
- Pop: pop = out_valid & out_ready. The head advances at the clock edge.
- Fetch/enqueue, decided per cycle:
  - fetch = !redirect_valid & (count < depth | pop).
  - On fetch: write {pc, imem_insn} at the tail and set pc <= pc + 4.
  - Otherwise pc holds. The ROM is re-read at the same address; no side effects.
- Count update: count <= count + fetch - pop. The count stays in range [0, depth] by construction.
- Full FIFO with pop in the same cycle: fetch is still allowed, so count is unchanged and throughput is 1 instruction/cycle.
- Empty FIFO with fetch: out_valid rises the next cycle. There is no same-cycle bypass; latency from fetch to out_valid is 1 cycle.
- Redirect (redirect_valid=1 in cycle N):
  - At the edge ending cycle N: count <= 0, pc <= {redirect_pc[address_size-1:2], 2'b00} (low two bits forced to zero), no enqueue.
  - Any pop in cycle N is still counted as consumed by decode, but flush dominates the FIFO state.
  - Cycle N+1: out_valid=0, imem_addr=target.
  - Cycle N+2: out_valid=1 with out_pc=target (absent another redirect).
- Redirect while rst_n=0: reset wins.
- PC arithmetic: modulo 2^address_size. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- Pointers: read/write pointers of log2(depth) bits wrap naturally. A full FIFO is distinguished from empty by count, not by pointer equality.
- Throughput: with out_ready held high and no redirects, exactly one instruction is delivered per cycle after the first.

Test Plan:
- Startup: ROM words 0x00500093, 0x00300113, 0x002081b3 at 0x0/0x4/0x8; release rst_n; hold out_ready=1 -> out_valid first high 1 cycle after release, with out_pc 0x0, 0x4, 0x8 and matching insns on consecutive cycles.
- Backpressure: out_ready=0 for 4 cycles after release -> count saturates at 2; imem_addr holds 0x8; head stays pc=0x0. Raise out_ready -> 0x0, 0x4, 0x8 delivered back-to-back with no gap or duplicate.
- Redirect with simultaneous pop: FIFO full (0x0, 0x4), out_ready=1, redirect_valid=1, redirect_pc=0x40 -> next cycle out_valid=0 and imem_addr=0x40; following cycle out_pc=0x40; 0x4 is never presented.
- Misaligned redirect: redirect_pc=0x103 -> imem_addr=0x100, then out_pc=0x100.
- Wrap: redirect to 0xFFFFFFFC with out_ready=1 -> out_pc sequence 0xFFFFFFFC, 0x00000000, 0x00000004.
- Mid-run reset: assert rst_n=0 for one edge while FIFO holds 2 entries -> out_valid=0, out_pc=0, imem_addr=reset_pc. After release the sequence restarts at reset_pc.
